// File: rtl/aes_key_expand.sv
// Iterative AES-128/192/256 key schedule: one word per step through a shared external S-box.
// Round keys leave on a valid/ready handshake. Define AES_RK_STORE_EN to add the round-key readback store.
module aes_key_expand #(
  parameter int SBOX_LAT = 1,
  parameter int RK_DEPTH = 15
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         start_i,
  input  logic [1:0]   key_len_i,
  input  logic [255:0] key_i,
  output logic [31:0]  sub_o,
  input  logic [31:0]  sub_i,
  output logic [127:0] rk_o,
  output logic [3:0]   rk_idx_o,
  output logic         rk_valid_o,
  input  logic         rk_ready_i,
  output logic         busy_o,
  output logic         done_o,
  output logic         err_o
`ifdef AES_RK_STORE_EN
  ,
  input  logic [3:0]   rd_addr_i,
  output logic [127:0] rd_data_o,
  output logic         rd_valid_o
`endif
);

  typedef enum logic [2:0] {IDLE, LOAD, EXPAND, SUBWAIT, EMIT, DONE} state_e;

  if (SBOX_LAT != 0 && SBOX_LAT != 1) begin : g_bad_lat
    $error("SBOX_LAT must be 0 or 1");
  end
  if (RK_DEPTH < 15) begin : g_bad_depth
    $error("RK_DEPTH must be at least 15");
  end

  state_e         state_q, state_d;
  logic [31:0]    win_q [8];
  logic [31:0]    win_d [8];
  logic [255:0]   key_q, key_d;
  logic [1:0]     klen_q, klen_d;
  logic [5:0]     i_q, i_d;
  logic [2:0]     kpos_q, kpos_d;
  logic [7:0]     rcon_q, rcon_d;
  logic [127:0]   rk_q, rk_d;
  logic [3:0]     rk_idx_q, rk_idx_d;
  logic           err_q, err_d;

  logic [3:0]     nk, nr;
  logic [5:0]     nw;
  logic           rot_step, sub_step, do_push, emit_chk;
  logic [31:0]    sub_req, sbox_temp, push_temp, new_w;
  logic [2:0]     old_pos, base;
  logic [6:0]     need_q, need_d;

  always_comb begin
    unique case (klen_q)
      2'd0:    begin nk = 4'd4; nr = 4'd10; nw = 6'd44; end
      2'd1:    begin nk = 4'd6; nr = 4'd12; nw = 6'd52; end
      default: begin nk = 4'd8; nr = 4'd14; nw = 6'd60; end
    endcase
  end

  // Window holds the newest word at [7]; w[i-Nk] therefore sits at 8-Nk.
  assign old_pos   = 3'd0 - nk[2:0];
  assign rot_step  = (kpos_q == 3'd0);
  assign sub_step  = rot_step || (klen_q == 2'd2 && kpos_q == 3'd4);
  assign sub_req   = rot_step ? {win_q[7][23:0], win_q[7][31:24]} : win_q[7];
  assign sbox_temp = sub_i ^ {(rot_step ? rcon_q : 8'h00), 24'h0};
  assign need_q    = {1'b0, rk_idx_q, 2'b00} + 7'd4;

  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    key_d     = key_q;
    klen_d    = klen_q;
    i_d       = i_q;
    kpos_d    = kpos_q;
    rcon_d    = rcon_q;
    rk_d      = rk_q;
    rk_idx_d  = rk_idx_q;
    err_d     = 1'b0;
    sub_o     = 32'h0;
    do_push   = 1'b0;
    push_temp = 32'h0;
    emit_chk  = 1'b0;
    new_w     = 32'h0;
    base      = 3'd0;
    need_d    = 7'd0;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          if (key_len_i == 2'd3) begin
            err_d = 1'b1;
          end else begin
            key_d    = key_i;
            klen_d   = key_len_i;
            i_d      = 6'd0;
            kpos_d   = 3'd0;
            rcon_d   = 8'h01;
            rk_idx_d = 4'd0;
            state_d  = LOAD;
          end
        end
      end
      LOAD: begin
        for (int k = 0; k < 8; k++) win_d[k] = 32'h0;
        unique case (klen_q)
          2'd0:    for (int k = 0; k < 4; k++) win_d[k + 4] = key_q[255 - 32*k -: 32];
          2'd1:    for (int k = 0; k < 6; k++) win_d[k + 2] = key_q[255 - 32*k -: 32];
          default: for (int k = 0; k < 8; k++) win_d[k]     = key_q[255 - 32*k -: 32];
        endcase
        i_d      = {2'b00, nk};
        kpos_d   = 3'd0;
        emit_chk = 1'b1;
      end
      EXPAND: begin
        // AES-256 has round key 1 ready straight from the load.
        if ({1'b0, i_q} >= need_q) begin
          emit_chk = 1'b1;
        end else if (sub_step) begin
          sub_o = sub_req;
          if (SBOX_LAT == 0) begin
            do_push   = 1'b1;
            push_temp = sbox_temp;
            emit_chk  = 1'b1;
          end else begin
            state_d = SUBWAIT;
          end
        end else begin
          do_push   = 1'b1;
          push_temp = win_q[7];
          emit_chk  = 1'b1;
        end
      end
      SUBWAIT: begin
        sub_o     = sub_req;
        do_push   = 1'b1;
        push_temp = sbox_temp;
        emit_chk  = 1'b1;
        state_d   = EXPAND;
      end
      EMIT: begin
        if (rk_ready_i) begin
          if (rk_idx_q == nr) begin
            state_d = DONE;
          end else begin
            rk_idx_d = rk_idx_q + 4'd1;
            state_d  = EXPAND;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (do_push) begin
      new_w = win_q[old_pos] ^ push_temp;
      for (int k = 0; k < 7; k++) win_d[k] = win_q[k + 1];
      win_d[7] = new_w;
      i_d      = (i_q == nw) ? i_q : i_q + 6'd1;
      kpos_d   = ({1'b0, kpos_q} + 4'd1 == nk) ? 3'd0 : kpos_q + 3'd1;
      // Skip the final xtime so rcon stops at the last value the key size uses.
      if (rot_step && (({1'b0, i_q} + {3'b000, nk}) < {1'b0, nw}))
        rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
    end

    if (emit_chk) begin
      need_d = {1'b0, rk_idx_d, 2'b00} + 7'd4;
      if ({1'b0, i_d} >= need_d) begin
        base    = {rk_idx_d[0], 2'b00} - i_d[2:0];
        rk_d    = {win_d[base], win_d[base + 3'd1], win_d[base + 3'd2], win_d[base + 3'd3]};
        state_d = EMIT;
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= IDLE;
      for (int k = 0; k < 8; k++) win_q[k] <= 32'h0;
      key_q    <= '0;
      klen_q   <= 2'd0;
      i_q      <= 6'd0;
      kpos_q   <= 3'd0;
      rcon_q   <= 8'h01;
      rk_q     <= '0;
      rk_idx_q <= 4'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      key_q    <= key_d;
      klen_q   <= klen_d;
      i_q      <= i_d;
      kpos_q   <= kpos_d;
      rcon_q   <= rcon_d;
      rk_q     <= rk_d;
      rk_idx_q <= rk_idx_d;
      err_q    <= err_d;
    end
  end

  assign rk_o       = rk_q;
  assign rk_idx_o   = rk_idx_q;
  assign rk_valid_o = (state_q == EMIT);
  assign busy_o     = (state_q != IDLE);
  assign done_o     = (state_q == DONE);
  assign err_o      = err_q;

`ifdef AES_RK_STORE_EN
  logic [127:0] mem_q [RK_DEPTH];
  logic [3:0]   last_q;
  logic         any_q;
  logic [127:0] rd_data_q;
  logic         rd_valid_q;
  logic         rd_hit;

  assign rd_hit = any_q && (state_q == IDLE) && (rd_addr_i <= last_q);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int k = 0; k < RK_DEPTH; k++) mem_q[k] <= '0;
      last_q     <= 4'd0;
      any_q      <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_hit;
      rd_data_q  <= rd_hit ? mem_q[rd_addr_i] : '0;
      if (state_q == IDLE && start_i && key_len_i != 2'd3) begin
        for (int k = 0; k < RK_DEPTH; k++) mem_q[k] <= '0;
        last_q <= 4'd0;
        any_q  <= 1'b0;
      end else if (state_q == EMIT && rk_ready_i) begin
        mem_q[rk_idx_q] <= rk_q;
        last_q          <= rk_idx_q;
        any_q           <= 1'b1;
      end
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;
`endif

endmodule

// File: tb/tb_aes_key_expand.sv
// Bench for aes_key_expand: random and known keys checked against a FIPS-197 key-schedule model.
`timescale 1ns/1ps
module tb_aes_key_expand;
  localparam int SBOX_LAT = 1;

  logic         clk = 1'b0;
  logic         nrst;
  logic         start_i;
  logic [1:0]   key_len_i;
  logic [255:0] key_i;
  logic [31:0]  sub_o;
  logic [31:0]  sub_i;
  logic [127:0] rk_o;
  logic [3:0]   rk_idx_o;
  logic         rk_valid_o;
  logic         rk_ready_i;
  logic         busy_o;
  logic         done_o;
  logic         err_o;
`ifdef AES_RK_STORE_EN
  logic [3:0]   rd_addr_i;
  logic [127:0] rd_data_o;
  logic         rd_valid_o;
`endif

  int errors = 0;
  int checks = 0;
  logic [7:0]   sbox_t [256];
  logic [31:0]  ref_w  [60];
  logic [127:0] got_rk [15];

  localparam logic [127:0] K128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [191:0] K192 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  always #5 clk = ~clk;

  aes_key_expand #(.SBOX_LAT(SBOX_LAT), .RK_DEPTH(15)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .start_i    (start_i),
    .key_len_i  (key_len_i),
    .key_i      (key_i),
    .sub_o      (sub_o),
    .sub_i      (sub_i),
    .rk_o       (rk_o),
    .rk_idx_o   (rk_idx_o),
    .rk_valid_o (rk_valid_o),
    .rk_ready_i (rk_ready_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o)
`ifdef AES_RK_STORE_EN
    ,
    .rd_addr_i  (rd_addr_i),
    .rd_data_o  (rd_data_o),
    .rd_valid_o (rd_valid_o)
`endif
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int k = 0; k < 8; k++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] a);
    return gmul(a, 8'h02);
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[32*k +: 32] = $urandom;
    return r;
  endfunction

  // S-box from its definition: multiplicative inverse in GF(2^8) then the affine map.
  task automatic build_sbox();
    logic [7:0] v8, inv, r, s;
    for (int v = 0; v < 256; v++) begin
      v8  = v[7:0];
      inv = 8'h00;
      if (v != 0)
        for (int x = 1; x < 256; x++)
          if (gmul(v8, x[7:0]) == 8'h01) inv = x[7:0];
      s = inv;
      r = inv;
      for (int k = 0; k < 4; k++) begin
        r = {r[6:0], r[7]};
        s = s ^ r;
      end
      sbox_t[v] = s ^ 8'h63;
    end
  endtask

  task automatic model_expand(input logic [255:0] key, input int nk);
    int nr;
    logic [31:0] t;
    logic [7:0] rc;
    nr = nk + 6;
    rc = 8'h01;
    for (int j = 0; j < nk; j++) ref_w[j] = key[255 - 32*j -: 32];
    for (int j = nk; j < 4*(nr+1); j++) begin
      t = ref_w[j-1];
      if (j % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk == 8 && j % nk == 4) begin
        t = subw(t);
      end
      ref_w[j] = ref_w[j-nk] ^ t;
    end
  endtask

  generate
    if (SBOX_LAT == 0) begin : g_sb0
      always_comb sub_i = subw(sub_o);
    end else begin : g_sb1
      always @(posedge clk) sub_i <= subw(sub_o);
    end
  endgenerate

  task automatic run_key(input logic [255:0] key, input logic [1:0] len, input bit rnd_ready,
                         input int stall_idx, input int stall_len, input bit inject,
                         input int reset_at);
    int nk, nr, n_acc, cyc, stall_cnt;
    bit fin, prev_hold, err_seen;
    logic [127:0] prev_rk, exp_rk;
    logic [3:0] prev_idx;
    nk = 4 + 2*int'(len);
    nr = nk + 6;
    model_expand(key, nk);
    @(negedge clk);
    key_i = key; key_len_i = len; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    key_i = rand256();
    n_acc = 0; cyc = 0; stall_cnt = 0;
    fin = 0; prev_hold = 0; err_seen = 0;
    prev_rk = '0; prev_idx = 4'd0;
    while (!fin && cyc < 3000) begin
      if (prev_hold) begin
        checks++;
        if (!rk_valid_o || rk_o !== prev_rk || rk_idx_o !== prev_idx || sub_o !== 32'h0) begin
          errors++;
          $display("FAIL hold_stable: valid=%0b idx=%0d rk=%h sub=%h required valid=1 idx=%0d rk=%h sub=0",
                   rk_valid_o, rk_idx_o, rk_o, sub_o, prev_idx, prev_rk);
        end
      end
      if (err_o) err_seen = 1;
      if (done_o) begin
        fin = 1;
        checks++;
        if (n_acc != nr + 1) begin
          errors++;
          $display("FAIL done_count: keys accepted=%0d required=%0d", n_acc, nr + 1);
        end
      end else begin
        if (reset_at >= 0 && rk_valid_o && rk_idx_o == 4'(reset_at)) begin
          nrst = 1'b0;
          #1;
          checks++;
          if ({rk_valid_o, busy_o, done_o, err_o, rk_idx_o} !== 8'h00 || rk_o !== '0 || sub_o !== '0) begin
            errors++;
            $display("FAIL reset_mid: valid=%0b busy=%0b done=%0b err=%0b idx=%0d rk=%h sub=%h required all 0",
                     rk_valid_o, busy_o, done_o, err_o, rk_idx_o, rk_o, sub_o);
          end
          @(negedge clk);
          nrst = 1'b1;
          @(negedge clk);
          return;
        end
        if (rk_valid_o && rk_idx_o == 4'(stall_idx) && stall_cnt < stall_len) begin
          rk_ready_i = 1'b0;
          stall_cnt++;
        end else begin
          rk_ready_i = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        if (inject && (cyc == 6 || cyc == 9)) begin
          start_i   = 1'b1;
          key_i     = rand256();
          key_len_i = (cyc == 6) ? 2'd0 : 2'd3;
        end
        if (rk_valid_o && rk_ready_i) begin
          checks++;
          if (n_acc > nr) begin
            errors++;
            $display("FAIL extra_key: idx=%0d accepted beyond %0d keys", rk_idx_o, nr + 1);
            fin = 1;
          end else begin
            exp_rk = {ref_w[4*n_acc], ref_w[4*n_acc+1], ref_w[4*n_acc+2], ref_w[4*n_acc+3]};
            if (rk_idx_o !== 4'(n_acc) || rk_o !== exp_rk) begin
              errors++;
              $display("FAIL round_key: idx=%0d rk=%h required idx=%0d rk=%h", rk_idx_o, rk_o, n_acc, exp_rk);
            end
            got_rk[n_acc] = rk_o;
            n_acc++;
          end
        end
        prev_hold = rk_valid_o && !rk_ready_i;
        prev_rk   = rk_o;
        prev_idx  = rk_idx_o;
        if (!fin) begin
          @(negedge clk);
          start_i = 1'b0;
          cyc++;
        end
      end
    end
    start_i = 1'b0;
    rk_ready_i = 1'b1;
    checks++;
    if (!fin) begin
      errors++;
      $display("FAIL timeout: keys accepted=%0d of %0d, no done after %0d cycles", n_acc, nr + 1, cyc);
    end
    @(negedge clk);
    checks++;
    if (done_o !== 1'b0 || busy_o !== 1'b0 || err_seen) begin
      errors++;
      $display("FAIL after_done: done=%0b busy=%0b err_seen=%0b required 0 0 0", done_o, busy_o, err_seen);
    end
  endtask

  task automatic test_reset();
    nrst = 1'b0; start_i = 1'b0; key_len_i = 2'd0; key_i = '0; rk_ready_i = 1'b1;
`ifdef AES_RK_STORE_EN
    rd_addr_i = 4'd0;
`endif
    repeat (3) @(negedge clk);
    checks++;
    if ({rk_valid_o, busy_o, done_o, err_o} !== 4'b0 || rk_o !== '0 || rk_idx_o !== 4'd0 || sub_o !== '0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%0b busy=%0b done=%0b err=%0b rk=%h idx=%0d sub=%h required 0",
               rk_valid_o, busy_o, done_o, err_o, rk_o, rk_idx_o, sub_o);
    end
    nrst = 1'b1;
    @(negedge clk);
    checks++;
    if ({rk_valid_o, busy_o, done_o, err_o} !== 4'b0) begin
      errors++;
      $display("FAIL idle_after_reset: valid=%0b busy=%0b done=%0b err=%0b required 0",
               rk_valid_o, busy_o, done_o, err_o);
    end
  endtask

  task automatic check_k128_vectors(input string tag);
    checks++;
    if (got_rk[0] !== K128 || got_rk[1] !== 128'ha0fafe1788542cb123a339392a6c7605 ||
        got_rk[10] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
      errors++;
      $display("FAIL %s: rk0=%h rk1=%h rk10=%h required %h a0fafe1788542cb123a339392a6c7605 d014f9a8c9ee2589e13f0cc8b6630ca6",
               tag, got_rk[0], got_rk[1], got_rk[10], K128);
    end
  endtask

  task automatic test_aes128();
    run_key({K128, rand256()[127:0]}, 2'd0, 0, -1, 0, 0, -1);
    check_k128_vectors("aes128_vectors");
  endtask

  task automatic test_aes192();
    run_key({K192, rand256()[63:0]}, 2'd1, 0, -1, 0, 0, -1);
    checks++;
    if (got_rk[12] !== 128'he98ba06f448c773c8ecc720401002202) begin
      errors++;
      $display("FAIL aes192_rk12: got %h required e98ba06f448c773c8ecc720401002202", got_rk[12]);
    end
  endtask

  task automatic test_aes256();
    run_key(K256, 2'd2, 0, -1, 0, 0, -1);
    checks++;
    if (got_rk[14] !== 128'hfe4890d1e6188d0b046df344706c631e || got_rk[2][127:96] !== 32'h9ba35411) begin
      errors++;
      $display("FAIL aes256_vectors: rk14=%h w8=%h required fe4890d1e6188d0b046df344706c631e 9ba35411",
               got_rk[14], got_rk[2][127:96]);
    end
  endtask

  task automatic test_backpressure();
    run_key({K128, 128'h0}, 2'd0, 0, 3, 5, 0, -1);
    check_k128_vectors("backpressure_vectors");
  endtask

  task automatic test_illegal();
    @(negedge clk);
    key_i = rand256(); key_len_i = 2'd3; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    checks++;
    if (err_o !== 1'b1 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL illegal_start: err=%0b busy=%0b required err=1 busy=0", err_o, busy_o);
    end
    @(negedge clk);
    checks++;
    if (err_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL illegal_pulse: err=%0b busy=%0b required err=0 busy=0", err_o, busy_o);
    end
  endtask

  task automatic test_ignored_start();
    run_key({K128, 128'h0}, 2'd0, 0, -1, 0, 1, -1);
    check_k128_vectors("ignored_start_vectors");
  endtask

  task automatic test_reset_mid();
    run_key(K256, 2'd2, 0, -1, 0, 0, 6);
    checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_idle: busy=%0b done=%0b required 0 0", busy_o, done_o);
    end
    run_key({K128, 128'h0}, 2'd0, 0, -1, 0, 0, -1);
    check_k128_vectors("restart_vectors");
`ifdef AES_RK_STORE_EN
    rd_addr_i = 4'd10;
    @(negedge clk);
    checks++;
    if (rd_valid_o !== 1'b1 || rd_data_o !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
      errors++;
      $display("FAIL store_rd10: valid=%0b data=%h required 1 d014f9a8c9ee2589e13f0cc8b6630ca6", rd_valid_o, rd_data_o);
    end
    rd_addr_i = 4'd11;
    @(negedge clk);
    checks++;
    if (rd_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL store_rd11: valid=%0b required 0", rd_valid_o);
    end
`endif
  endtask

  task automatic test_back_to_back();
    logic [1:0] len;
    int nr;
    for (int n = 0; n < 6; n++) begin
      len = 2'($urandom_range(0, 2));
      nr  = 10 + 2*int'(len);
      run_key(rand256(), len, 1, -1, 0, 0, -1);
`ifdef AES_RK_STORE_EN
      for (int a = nr; a >= 0; a--) begin
        rd_addr_i = 4'(a);
        @(negedge clk);
        checks++;
        if (rd_valid_o !== 1'b1 || rd_data_o !== {ref_w[4*a], ref_w[4*a+1], ref_w[4*a+2], ref_w[4*a+3]}) begin
          errors++;
          $display("FAIL store_reverse: addr=%0d valid=%0b data=%h required valid=1 data=%h", a, rd_valid_o,
                   rd_data_o, {ref_w[4*a], ref_w[4*a+1], ref_w[4*a+2], ref_w[4*a+3]});
        end
      end
`endif
    end
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_aes128();
    test_aes192();
    test_aes256();
    test_backpressure();
    test_illegal();
    test_ignored_start();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
